uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `buart` transmitter between two byte producers: requester 0 is the CPU store path and requester 1 is a debug/trace source. Accepted bytes are buffered in a small FIFO, then issued to the UART one at a time with a one-cycle write strobe, honouring its `busy` flag. The block sits between the memory-mapped I/O decode and the `buart` instance, which sees one write port. A flush input, driven by the UART `brk` pulse, drops pending output.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `BUSY_TIMEOUT`, default 4: maximum cycles to wait for `tx_busy` to rise after a write strobe.
- `clk` in 1: system clock; all logic on the rising edge.
- `resetq` in 1: reset, synchronous, active-low.
- `flush` in 1: one-cycle request to discard FIFO contents.
- `req0_valid` in 1, `req0_data` in 8, `req0_ready` out 1: requester 0 handshake.
- `req1_valid` in 1, `req1_data` in 8, `req1_ready` out 1: requester 1 handshake.
- `tx_wr` out 1: one-cycle write strobe to the UART.
- `tx_data` out 8: byte presented with `tx_wr`.
- `tx_busy` in 1: UART transmitter busy.
- `fifo_count` out log2(FIFO_DEPTH)+1: current occupancy.
- `last_grant` out 1: index of the requester most recently accepted.

## Operation
- **Reset** (`resetq`=0 at an edge):
  - FIFO empty; `fifo_count`=0.
  - FSM in IDLE.
  - `tx_wr`=0, `tx_data`=0.
  - `last_grant`=1, so requester 0 has first priority.
  - Timeout counter 0.
  - Reset mid-transmission abandons the byte without a further strobe.
- **Arbitration:**
  - At most one byte is accepted per cycle.
  - When both requesters are valid, the one not equal to `last_grant` wins.
  - `reqN_ready` = !full && !flush && (requester N is the winner, or the other requester is not valid).
  - `reqN_ready` is combinational from `valid`, the registered full flag and `last_grant`.
  - A transfer occurs on `valid && ready`; `last_grant` updates to N.
  - Full is computed from registered occupancy. No push happens when full, even on a cycle that pops.
- **FSM:**
  - IDLE: if FIFO is non-empty and `tx_busy`=0, register `tx_wr`=1 with `tx_data`=head, pop, clear the timeout counter, and go to WAIT_BUSY.
  - WAIT_BUSY: `tx_wr`=0. Go to WAIT_DONE when `tx_busy`=1 or the counter reaches BUSY_TIMEOUT-1; otherwise increment the counter.
  - WAIT_DONE: go to IDLE when `tx_busy`=0.
- **Flush:**
  - Resets the read and write pointers and `fifo_count` to 0 at that edge.
  - A push in the same cycle is blocked, because ready is low.
  - A pop in the same cycle still completes: the strobe is issued and the FIFO ends empty.
  - The FSM is not reset; an in-flight byte finishes normally.
- **Pointers:** wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves `fifo_count` unchanged.

## Timing
- Accepting edge k → FIFO visible after k. If the FSM is in IDLE and `tx_busy`=0, `tx_wr` is high in the cycle following edge k+1, giving 2-cycle latency.
- `tx_wr` is never high in two consecutive cycles. Minimum spacing between strobes is 3 cycles, even with `tx_busy` stuck low, because of the timeout path.
- `tx_data` holds the last issued byte until the next strobe.
- `fifo_count` and `last_grant` are registered and update at the edge of the transfer.
- With `tx_busy` stuck high, the FSM stays in WAIT_DONE or IDLE. The FIFO fills; ready drops when `fifo_count`=FIFO_DEPTH.

## Structure
- No shared package needed.
- The FSM state encoding (IDLE/WAIT_BUSY/WAIT_DONE) uses localparams inside the module.
- One sub-module: `uart_tx_fifo`, a synchronous FIFO with push/pop/flush, registered count and full/empty.
- Arbiter and FSM live in the top module.

## Test plan
- **Single byte:** reset, then `req0` sends 0x41 with `tx_busy` held 0. Expect `tx_wr` high for exactly 1 cycle, 2 cycles after acceptance, `tx_data`=0x41, `fifo_count` returns to 0.
- **Contention:** both requesters valid every cycle with data 0x10.. and 0x80.. Expect acceptance alternating 0,1,0,1 starting with 0, and UART output order 0x10,0x80,0x11,0x81.
- **Back-pressure:** `tx_busy` held 1, with 6 bytes offered from `req0`. Expect 4 accepted, `req0_ready`=0 and `fifo_count`=4. Release busy: the 4 bytes go out in order with one strobe per busy low-period.
- **Timeout:** `tx_busy` never asserts. Expect WAIT_BUSY to exit after 4 cycles and strobes to be spaced ≥3 cycles apart.
- **Flush:** FIFO holds 3 bytes while byte 1 is in flight. Pulse `flush` with `req1_valid`=1. Expect `fifo_count`=0 the next cycle, `req1_ready`=0 during flush, the in-flight byte unaffected and no further strobes.
- **Reset mid-operation:** `resetq`=0 while in WAIT_DONE with 2 bytes queued. Expect all outputs at their reset values and no strobe after reset is released until new input arrives.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshakes, UART write port and status for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          req0_valid;
    logic [7:0]    req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [7:0]    req1_data;
    logic          req1_ready;
    logic          tx_wr;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;
    logic          last_grant;

    // Requesters and UART side: drive requests and busy, observe everything else.
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_wr, tx_data, fifo_count, last_grant
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_wr, tx_data, fifo_count, last_grant
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with push/pop/flush and registered count
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetq,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the registered count, so a pop never frees room for a same-cycle push.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy update; flush empties the queue even if a pop is in progress.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin front end feeding one UART write port
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              flush,
    uart_tx_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_BUSY = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

    logic [1:0]    state;
    logic [TW-1:0] tcnt;
    logic          tx_wr_q;
    logic [7:0]    tx_data_q;
    logic          last_grant_q;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          ready0;
    logic          ready1;
    logic          take0;
    logic          take1;
    logic          push;
    logic [7:0]    push_data;
    logic          pop;

    // On contention the requester that did not win last time gets the slot.
    assign ready0    = !full && !flush && (last_grant_q || !bus.req1_valid);
    assign ready1    = !full && !flush && (!last_grant_q || !bus.req0_valid);
    assign take0     = bus.req0_valid && ready0;
    assign take1     = bus.req1_valid && ready1;
    assign push      = take0 || take1;
    assign push_data = take0 ? bus.req0_data : bus.req1_data;
    assign pop       = (state == IDLE) && !empty && !bus.tx_busy;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.tx_wr      = tx_wr_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.fifo_count = count;
    assign bus.last_grant = last_grant_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetq    (resetq),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Remember who was accepted last; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            last_grant_q <= 1'b1;
        end else if (take0) begin
            last_grant_q <= 1'b0;
        end else if (take1) begin
            last_grant_q <= 1'b1;
        end
    end

    // Issue one byte, wait for busy to rise (or time out), then wait for it to fall.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state     <= IDLE;
            tcnt      <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    tx_wr_q <= 1'b0;
                    if (pop) begin
                        tx_wr_q   <= 1'b1;
                        tx_data_q <= head;
                        tcnt      <= '0;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    tx_wr_q <= 1'b0;
                    if (bus.tx_busy || tcnt == TW'(BUSY_TIMEOUT - 1)) begin
                        state <= WAIT_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    tx_wr_q <= 1'b0;
                    if (!bus.tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_wr_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic resetq = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;

    uart_tx_arbiter_if #(.FIFO_DEPTH(4)) bus ();

    uart_tx_arbiter #(
        .FIFO_DEPTH   (4),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk    (clk),
        .resetq (resetq),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v0;
        logic v1;
        logic fl;
        logic r0;
        logic r1;
        logic lg;
        int   cnt;
    } vec_t;

    vec_t     vecs[11];
    logic [7:0] sb[$];
    int       busy_mode = 1;
    int       busy_len = 3;
    int       busy_cnt = 0;
    int       cyc = 0;
    int       strobe_cnt = 0;
    int       last_strobe_cyc = 0;
    int       last_gap = 0;
    logic     prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // UART model and scoreboard consumer, sampled 1ns after each rising edge.
    initial begin
        bus.tx_busy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.tx_wr === 1'b1) begin
                check("no_back_to_back_strobe", {31'd0, prev_wr}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_data_order", {24'd0, bus.tx_data}, {24'd0, sb.pop_front()});
                end
                last_gap = cyc - last_strobe_cyc;
                last_strobe_cyc = cyc;
                strobe_cnt++;
            end
            prev_wr = bus.tx_wr;
            if (busy_mode == 0) begin
                busy_cnt = 0;
                bus.tx_busy = 1'b0;
            end else if (busy_mode == 1) begin
                busy_cnt = 0;
                bus.tx_busy = 1'b1;
            end else begin
                if (bus.tx_wr === 1'b1) busy_cnt = busy_len;
                bus.tx_busy = (busy_cnt > 0);
                if (busy_cnt > 0) busy_cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetq = 1'b0;
        flush = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data = 8'h00;
        bus.req1_data = 8'h00;
        tick();
        tick();
        resetq = 1'b1;
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check(name, sb.size(), 0);
        repeat (8) tick();
    endtask

    task automatic wait_strobe(input int base, input int limit, input string name);
        int n = 0;
        while (strobe_cnt == base && n < limit) begin
            tick();
            n++;
        end
        check(name, {31'd0, strobe_cnt != base}, 32'd1);
    endtask

    task automatic push0(input logic [7:0] d, input logic to_sb);
        bus.req0_valid = 1'b1;
        bus.req0_data = d;
        #1;
        check("push0_ready", {31'd0, bus.req0_ready}, 32'd1);
        if (to_sb) sb.push_back(d);
        tick();
        bus.req0_valid = 1'b0;
    endtask

    initial begin
        int base;
        int n0;
        int n1;
        int g;
        int acc;
        int seen;
        // v0 v1 fl | r0 r1 | last_grant, count after edge (tx_busy held high)
        vecs[0]  = '{1, 1, 0, 1, 0, 0, 1};
        vecs[1]  = '{1, 1, 0, 0, 1, 1, 2};
        vecs[2]  = '{0, 1, 0, 1, 1, 1, 3};
        vecs[3]  = '{1, 1, 1, 0, 0, 1, 0};
        vecs[4]  = '{1, 0, 0, 1, 0, 0, 1};
        vecs[5]  = '{0, 0, 0, 1, 1, 0, 1};
        vecs[6]  = '{0, 1, 0, 0, 1, 1, 2};
        vecs[7]  = '{1, 0, 0, 1, 0, 0, 3};
        vecs[8]  = '{1, 1, 0, 0, 1, 1, 4};
        vecs[9]  = '{1, 1, 0, 0, 0, 1, 4};
        vecs[10] = '{1, 0, 1, 0, 0, 1, 0};

        // Reset values and arbitration table.
        busy_mode = 1;
        do_reset();
        check("rst_fifo_count", {29'd0, bus.fifo_count}, 32'd0);
        check("rst_last_grant", {31'd0, bus.last_grant}, 32'd1);
        check("rst_tx_wr", {31'd0, bus.tx_wr}, 32'd0);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        for (int i = 0; i < 11; i++) begin
            bus.req0_valid = vecs[i].v0;
            bus.req1_valid = vecs[i].v1;
            bus.req0_data = 8'(i);
            bus.req1_data = 8'(8'h40 + i);
            flush = vecs[i].fl;
            #1;
            check($sformatf("vec%0d_r0", i), {31'd0, bus.req0_ready}, {31'd0, vecs[i].r0});
            check($sformatf("vec%0d_r1", i), {31'd0, bus.req1_ready}, {31'd0, vecs[i].r1});
            tick();
            check($sformatf("vec%0d_last_grant", i), {31'd0, bus.last_grant}, {31'd0, vecs[i].lg});
            check($sformatf("vec%0d_count", i), {29'd0, bus.fifo_count}, vecs[i].cnt);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        flush = 1'b0;
        base = strobe_cnt;
        busy_mode = 0;
        repeat (12) tick();
        check("flushed_no_strobe", strobe_cnt, base);

        // Single byte: strobe exactly two cycles after acceptance.
        busy_mode = 0;
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data = 8'h41;
        #1;
        check("single_ready", {31'd0, bus.req0_ready}, 32'd1);
        sb.push_back(8'h41);
        tick();
        bus.req0_valid = 1'b0;
        check("single_count_k", {29'd0, bus.fifo_count}, 32'd1);
        check("single_wr_k", {31'd0, bus.tx_wr}, 32'd0);
        tick();
        check("single_wr_k1", {31'd0, bus.tx_wr}, 32'd1);
        check("single_data", {24'd0, bus.tx_data}, 32'h41);
        check("single_count_k1", {29'd0, bus.fifo_count}, 32'd0);
        tick();
        check("single_wr_k2", {31'd0, bus.tx_wr}, 32'd0);
        check("single_data_hold", {24'd0, bus.tx_data}, 32'h41);
        wait_drain(50, "single_drain");

        // Contention: alternating grants starting at requester 0.
        busy_mode = 2;
        busy_len = 3;
        do_reset();
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 4; i++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            bus.req0_data = 8'(8'h10 + n0);
            bus.req1_data = 8'(8'h80 + n1);
            #1;
            g = i & 1;
            check($sformatf("cont%0d_r0", i), {31'd0, bus.req0_ready}, (g == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_r1", i), {31'd0, bus.req1_ready}, (g == 1) ? 32'd1 : 32'd0);
            if (g == 1) begin
                sb.push_back(8'(8'h80 + n1));
                n1++;
            end else begin
                sb.push_back(8'(8'h10 + n0));
                n0++;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_drain(200, "cont_drain");

        // Back-pressure: busy stuck high, FIFO fills at four.
        busy_mode = 1;
        do_reset();
        acc = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data = 8'(8'hA0 + acc);
            #1;
            if (bus.req0_ready === 1'b1) seen++;
            if (acc < 4) begin
                sb.push_back(8'(8'hA0 + acc));
                acc++;
            end
            tick();
        end
        #1;
        check("bp_accepted", seen, 4);
        check("bp_ready_low", {31'd0, bus.req0_ready}, 32'd0);
        check("bp_count_full", {29'd0, bus.fifo_count}, 32'd4);
        bus.req0_valid = 1'b0;
        busy_len = 3;
        busy_mode = 2;
        wait_drain(200, "bp_drain");

        // Timeout: busy never rises, strobes spaced by the timeout path.
        busy_mode = 0;
        do_reset();
        bus.req1_valid = 1'b1;
        bus.req1_data = 8'h55;
        #1;
        check("to_ready_a", {31'd0, bus.req1_ready}, 32'd1);
        sb.push_back(8'h55);
        tick();
        bus.req1_data = 8'h66;
        #1;
        check("to_ready_b", {31'd0, bus.req1_ready}, 32'd1);
        sb.push_back(8'h66);
        tick();
        bus.req1_valid = 1'b0;
        wait_drain(100, "to_drain");
        check("to_strobe_gap", last_gap, 6);

        // Flush while byte 1 is in flight.
        busy_mode = 1;
        do_reset();
        push0(8'hC0, 1'b1);
        push0(8'hC1, 1'b0);
        push0(8'hC2, 1'b0);
        push0(8'hC3, 1'b0);
        check("fl_count_loaded", {29'd0, bus.fifo_count}, 32'd4);
        busy_len = 8;
        busy_mode = 2;
        base = strobe_cnt;
        wait_strobe(base, 20, "fl_first_strobe");
        check("fl_count_inflight", {29'd0, bus.fifo_count}, 32'd3);
        flush = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_data = 8'hEE;
        #1;
        check("fl_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        flush = 1'b0;
        bus.req1_valid = 1'b0;
        check("fl_count_zero", {29'd0, bus.fifo_count}, 32'd0);
        repeat (30) tick();
        check("fl_one_strobe", strobe_cnt - base, 1);
        check("fl_sb_empty", sb.size(), 0);

        // Reset while in WAIT_DONE with two bytes queued.
        busy_mode = 1;
        do_reset();
        push0(8'hD0, 1'b1);
        push0(8'hD1, 1'b0);
        push0(8'hD2, 1'b0);
        busy_len = 20;
        busy_mode = 2;
        base = strobe_cnt;
        wait_strobe(base, 20, "rm_first_strobe");
        repeat (3) tick();
        check("rm_count_queued", {29'd0, bus.fifo_count}, 32'd2);
        resetq = 1'b0;
        tick();
        check("rm_tx_wr", {31'd0, bus.tx_wr}, 32'd0);
        check("rm_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("rm_count", {29'd0, bus.fifo_count}, 32'd0);
        check("rm_last_grant", {31'd0, bus.last_grant}, 32'd1);
        busy_mode = 0;
        resetq = 1'b1;
        base = strobe_cnt;
        repeat (15) tick();
        check("rm_no_strobe", strobe_cnt, base);
        bus.req1_valid = 1'b1;
        bus.req1_data = 8'h5A;
        #1;
        check("rm_new_ready", {31'd0, bus.req1_ready}, 32'd1);
        sb.push_back(8'h5A);
        tick();
        bus.req1_valid = 1'b0;
        wait_drain(50, "rm_new_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
